// File: rtl/fifo_pkg.sv
// Shared constants and width helper for the single-clock FIFO controller.
package fifo_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_RAM_DEPTH  = 1024;
    localparam int DEF_AFULL_LVL  = 1020;

    // Returns ceil(log2(value)), minimum 1: the bits needed to index 0..value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return (result == 0) ? 1 : result;
    endfunction
endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Push/pop/status bundle between a FIFO user (master) and sync_fifo_ctrl (slave).
interface sync_fifo_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH+1:0] count;
    logic                  afull;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data, count, afull
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data, count, afull
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry output queue that absorbs RAM read data; head is a register so
// the pop side sees first-word-fall-through data with no combinational path.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_count,
    output logic                  o_valid
);
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [1:0]            cnt_q;
    logic                  pop_ok;
    logic                  push_ok;

    // An empty queue cannot pop; a full queue only accepts when it also pops.
    assign pop_ok  = i_pop & (cnt_q != 2'd0);
    assign push_ok = i_push & ((cnt_q != 2'd2) | pop_ok);

    // Shift head/tail on pop and enqueue behind whatever remains.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= i_push_data;
                    else               tail_q <= i_push_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= i_push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = head_q;
    assign o_count = cnt_q;
    assign o_valid = (cnt_q != 2'd0);
endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller in front of an external dual-port RAM with a
// 1-cycle registered read. Reads are prefetched into a 2-entry skid queue so
// the pop side runs at one word per cycle.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int RAM_DEPTH  = DEF_RAM_DEPTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AFULL_LVL  = DEF_AFULL_LVL
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sync_fifo_ctrl_if.slave       fifo_bus,
    output logic [ADDR_WIDTH-1:0] o_ram_waddr,
    output logic                  o_ram_wen,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    output logic [ADDR_WIDTH-1:0] o_ram_raddr,
    output logic                  o_ram_ren,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata
);
    localparam int CNT_W   = clog2(RAM_DEPTH + 1);
    localparam int COUNT_W = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] rptr_q;
    logic [CNT_W-1:0]      ram_cnt_q;
    logic [CNT_W-1:0]      ram_cnt_nxt;
    logic                  inflight_q;
    logic                  afull_q;
    logic [1:0]            obuf_cnt;
    logic [2:0]            pending;
    logic                  push;
    logic                  pop_now;
    logic                  ren;

    assign fifo_bus.wr_ready = (ram_cnt_q != CNT_W'(RAM_DEPTH));
    assign push    = fifo_bus.wr_valid & fifo_bus.wr_ready;
    assign pop_now = fifo_bus.rd_valid & fifo_bus.rd_ready;

    // Entries the skid queue will hold once this cycle's pop and the
    // in-flight read settle; only issue a read if there is room for it.
    assign pending = {1'b0, obuf_cnt} + {2'b00, inflight_q} - {2'b00, pop_now};
    assign ren     = (ram_cnt_q != '0) & (pending < 3'd2);

    assign ram_cnt_nxt = ram_cnt_q + CNT_W'(push) - CNT_W'(ren);

    // Pointers, RAM occupancy, read pipeline stage and almost-full flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            if (push)
                wptr_q <= (wptr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            if (ren)
                rptr_q <= (rptr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            ram_cnt_q  <= ram_cnt_nxt;
            inflight_q <= ren;
            afull_q    <= (ram_cnt_nxt >= CNT_W'(AFULL_LVL));
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (inflight_q),
        .i_push_data (i_ram_rdata),
        .i_pop       (pop_now),
        .o_head      (fifo_bus.rd_data),
        .o_count     (obuf_cnt),
        .o_valid     (fifo_bus.rd_valid)
    );

    assign fifo_bus.count = COUNT_W'(ram_cnt_q) + COUNT_W'(inflight_q) + COUNT_W'(obuf_cnt);
    assign fifo_bus.afull = afull_q;

    assign o_ram_wen   = push;
    assign o_ram_waddr = wptr_q;
    assign o_ram_wdata = fifo_bus.wr_data;
    assign o_ram_ren   = ren;
    assign o_ram_raddr = rptr_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed and randomised bench for sync_fifo_ctrl with a behavioural RAM.
module tb_sync_fifo_ctrl;
    import fifo_pkg::*;

    logic       clk;
    logic       rst;
    logic [9:0] ram_waddr, ram_raddr;
    logic       ram_wen, ram_ren;
    logic [7:0] ram_wdata, ram_rdata;
    logic [7:0] mem [0:1023];

    sync_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

    sync_fifo_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .fifo_bus    (bus),
        .o_ram_waddr (ram_waddr),
        .o_ram_wen   (ram_wen),
        .o_ram_wdata (ram_wdata),
        .o_ram_raddr (ram_raddr),
        .o_ram_ren   (ram_ren),
        .i_ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM with registered read.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] sb [$];
    int         tb_ram = 0;
    int         tb_infl = 0;

    logic        s_wr_ready, s_rd_valid, s_afull, s_ren, s_wen;
    logic [7:0]  s_rd_data;
    logic [11:0] s_count;
    int          s_size, s_ram, s_infl;
    logic        did_push, did_pop;
    logic [7:0]  exp_head;

    // One cycle: drive inputs at negedge, sample the state left by the
    // previous edge, update the model for the coming edge.
    task automatic drive(input logic r, input logic wv, input logic [7:0] wd, input logic rr);
        @(negedge clk);
        rst = r;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        #1;
        s_wr_ready = bus.wr_ready;
        s_rd_valid = bus.rd_valid;
        s_rd_data  = bus.rd_data;
        s_count    = bus.count;
        s_afull    = bus.afull;
        s_ren      = ram_ren;
        s_wen      = ram_wen;
        s_size     = sb.size();
        s_ram      = tb_ram;
        s_infl     = tb_infl;
        exp_head   = (sb.size() != 0) ? sb[0] : 8'h00;
        if (r) begin
            did_push = 1'b0;
            did_pop  = 1'b0;
            sb.delete();
            tb_ram  = 0;
            tb_infl = 0;
        end else begin
            did_push = wv & s_wr_ready;
            did_pop  = s_rd_valid & rr;
            if (did_pop && sb.size() != 0) void'(sb.pop_front());
            if (did_push) sb.push_back(wd);
            tb_ram  = tb_ram + int'(did_push) - int'(s_ren);
            tb_infl = int'(s_ren);
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 8'h00, 0);
        drive(1, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0);
        n_cmp++; if (s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%0b exp=0", s_rd_valid); end
        n_cmp++; if (s_count !== 12'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", s_count); end
        n_cmp++; if (s_afull !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%0b exp=0", s_afull); end
        n_cmp++; if (s_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=00", s_rd_data); end
        n_cmp++; if (s_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%0b exp=1", s_wr_ready); end
        n_cmp++; if (s_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren got=%0b exp=0", s_ren); end
    endtask

    task automatic test_first_word();
        drive(0, 1, 8'h11, 0);
        drive(0, 1, 8'h22, 0);
        n_cmp++; if (s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL fw_valid_e0 got=%0b exp=0", s_rd_valid); end
        drive(0, 1, 8'h33, 0);
        n_cmp++; if (s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL fw_valid_e1 got=%0b exp=0", s_rd_valid); end
        drive(0, 0, 8'h00, 0);
        n_cmp++; if (s_rd_valid !== 1'b1) begin n_fail++; $display("FAIL fw_valid_e2 got=%0b exp=1", s_rd_valid); end
        n_cmp++; if (s_rd_data !== 8'h11) begin n_fail++; $display("FAIL fw_data_e2 got=%h exp=11", s_rd_data); end
        for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 0);
        n_cmp++; if (s_count !== 12'd3) begin n_fail++; $display("FAIL fw_count got=%0d exp=3", s_count); end
        n_cmp++; if (s_rd_data !== 8'h11) begin n_fail++; $display("FAIL fw_head_hold got=%h exp=11", s_rd_data); end
    endtask

    task automatic test_fill();
        int  accepted;
        logic full_seen;
        accepted  = 0;
        full_seen = 1'b0;
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 1100 && !full_seen; i++) begin
            drive(0, 1, 8'(i * 37 + 5), 0);
            n_cmp++; if (s_afull !== (s_ram >= 1020)) begin n_fail++; $display("FAIL fill_afull ram=%0d got=%0b exp=%0b", s_ram, s_afull, (s_ram >= 1020)); end
            n_cmp++; if (s_wr_ready !== (s_ram != 1024)) begin n_fail++; $display("FAIL fill_wr_ready ram=%0d got=%0b exp=%0b", s_ram, s_wr_ready, (s_ram != 1024)); end
            if (!s_wr_ready) begin
                full_seen = 1'b1;
                n_cmp++; if (s_count !== 12'd1026) begin n_fail++; $display("FAIL fill_count_full got=%0d exp=1026", s_count); end
                n_cmp++; if (accepted !== 1026) begin n_fail++; $display("FAIL fill_accepted got=%0d exp=1026", accepted); end
            end
            accepted += int'(did_push);
        end
        n_cmp++; if (!full_seen) begin n_fail++; $display("FAIL fill_timeout got=not_full exp=full"); end
        drive(0, 1, 8'hEE, 0);
        n_cmp++; if (s_wen !== 1'b0) begin n_fail++; $display("FAIL fill_extra_wen got=%0b exp=0", s_wen); end
        drive(0, 0, 8'h00, 0);
        n_cmp++; if (s_count !== 12'd1026) begin n_fail++; $display("FAIL fill_extra_count got=%0d exp=1026", s_count); end
        n_cmp++; if (s_afull !== 1'b1) begin n_fail++; $display("FAIL fill_afull_full got=%0b exp=1", s_afull); end
    endtask

    task automatic test_drain();
        int  pops;
        logic done;
        pops = 0;
        done = 1'b0;
        for (int i = 0; i < 1100 && !done; i++) begin
            drive(0, 0, 8'h00, 1);
            if (pops < 1026) begin
                n_cmp++; if (s_rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_bubble pop=%0d got=%0b exp=1", pops, s_rd_valid); end
                if (did_pop) begin
                    n_cmp++; if (s_rd_data !== exp_head) begin n_fail++; $display("FAIL drain_data pop=%0d got=%h exp=%h", pops, s_rd_data, exp_head); end
                end
                pops += int'(did_pop);
            end else begin
                done = 1'b1;
                n_cmp++; if (s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_end got=%0b exp=0", s_rd_valid); end
                n_cmp++; if (s_count !== 12'd0) begin n_fail++; $display("FAIL drain_count_end got=%0d exp=0", s_count); end
            end
        end
        n_cmp++; if (!done) begin n_fail++; $display("FAIL drain_timeout got=%0d exp=1026", pops); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5000; c++) begin
            drive(0, 1, 8'(c), 1);
            if (did_pop) begin
                n_cmp++; if (s_rd_data !== exp_head) begin n_fail++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, s_rd_data, exp_head); end
            end
            if (c >= 3) begin
                n_cmp++; if ({s_rd_valid, s_wr_ready} !== 2'b11) begin n_fail++; $display("FAIL stream_bubble c=%0d got=%b exp=11", c, {s_rd_valid, s_wr_ready}); end
                n_cmp++; if (s_count !== 12'd3) begin n_fail++; $display("FAIL stream_count c=%0d got=%0d exp=3", c, s_count); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 20000; c++) begin
            drive(0, 1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)));
            if (did_pop) begin
                n_cmp++; if (s_rd_data !== exp_head) begin n_fail++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, s_rd_data, exp_head); end
            end
            n_cmp++; if (s_count !== 12'(s_size)) begin n_fail++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, s_count, s_size); end
            n_cmp++; if (s_wr_ready !== (s_ram != 1024)) begin n_fail++; $display("FAIL rand_wr_ready c=%0d got=%0b exp=%0b", c, s_wr_ready, (s_ram != 1024)); end
            n_cmp++; if ((s_ren && s_ram == 0) !== 1'b0) begin n_fail++; $display("FAIL rand_ren_empty c=%0d got=1 exp=0", c); end
            n_cmp++; if ((s_size - s_ram - s_infl) > 2 || (s_size - s_ram - s_infl) < 0) begin n_fail++; $display("FAIL rand_obuf c=%0d got=%0d exp=0..2", c, s_size - s_ram - s_infl); end
        end
    endtask

    task automatic test_mid_reset();
        logic got;
        got = 1'b0;
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 0);
        n_cmp++; if (s_count !== 12'd7) begin n_fail++; $display("FAIL mrst_count_pre got=%0d exp=7", s_count); end
        drive(1, 0, 8'h00, 0);
        drive(0, 0, 8'h00, 0);
        n_cmp++; if (s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_rd_valid got=%0b exp=0", s_rd_valid); end
        n_cmp++; if (s_count !== 12'd0) begin n_fail++; $display("FAIL mrst_count got=%0d exp=0", s_count); end
        n_cmp++; if (s_wr_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_wr_ready got=%0b exp=1", s_wr_ready); end
        drive(0, 1, 8'hA5, 1);
        for (int i = 0; i < 10 && !got; i++) begin
            drive(0, 0, 8'h00, 1);
            if (did_pop) begin
                got = 1'b1;
                n_cmp++; if (s_rd_data !== 8'hA5) begin n_fail++; $display("FAIL mrst_data got=%h exp=a5", s_rd_data); end
            end
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL mrst_timeout got=no_pop exp=pop"); end
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_ready = 1'b0;
        test_reset();
        test_first_word();
        test_fill();
        test_drain();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
